// File: rtl/hssaer_tx_arbiter_pkg.sv
// Shared types and helpers for the HSSAER transmit-lane arbiter.
// Holds the FSM state enum, the index-width function and the tag inserter.
package hssaer_pkg;

  localparam int MAX_EV_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    KA   = 2'd2
  } state_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Overwrites ev[dsize-1 -: tag_w] with the low tag_w bits of idx.
  function automatic logic [MAX_EV_W-1:0] tag_event(
    input logic [MAX_EV_W-1:0] ev,
    input int                  dsize,
    input int                  tag_w,
    input int                  idx
  );
    logic [MAX_EV_W-1:0] r;
    r = ev;
    for (int b = 0; b < 8; b++) begin
      if (b < tag_w) r[dsize - tag_w + b] = idx[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/hssaer_tx_arbiter_if.sv
// Requester-side and lane-side handshake bundle of the TX arbiter.
// master = the arbiter, slave = the FIFOs plus TX wrapper around it.
interface hssaer_tx_arbiter_if #(
  parameter int N_CH      = 4,
  parameter int int_dsize = 24
);
  logic [N_CH*int_dsize-1:0] req_ae;
  logic [N_CH-1:0]           req_src_rdy;
  logic [N_CH-1:0]           req_dst_rdy;
  logic [int_dsize-1:0]      tx_ae;
  logic                      tx_src_rdy;
  logic                      tx_dst_rdy;
  logic                      tx_keep_alive;

  modport master (
    input  req_ae, req_src_rdy, tx_dst_rdy,
    output req_dst_rdy, tx_ae, tx_src_rdy, tx_keep_alive
  );

  modport slave (
    output req_ae, req_src_rdy, tx_dst_rdy,
    input  req_dst_rdy, tx_ae, tx_src_rdy, tx_keep_alive
  );
endinterface

// File: rtl/hssaer_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
// N_CH is a power of two, so the wrap is plain truncation of ptr + k.
module rr_arbiter
  import hssaer_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            valid
);

  logic [CH_W-1:0] cand;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = ptr + CH_W'(k);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        grant_idx = cand;
      end
    end
    if (valid) grant = N_CH'(1) << grant_idx;
  end

endmodule

// File: rtl/hssaer_tx_arbiter.sv
// Round-robin scheduler sharing one HSSAER/PAER TX lane between N_CH sources,
// with a 1-entry output register, optional source tagging and idle keep-alive.
module hssaer_tx_arbiter
  import hssaer_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int dsize     = 8,
  parameter  int int_dsize = 24,
  parameter  int TAG_EN    = 1,
  parameter  int KA_W      = 16,
  localparam int CH_W      = ch_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [KA_W-1:0]        ka_period,
  hssaer_tx_arbiter_if.master    bus,
  output logic [CH_W-1:0]        grant_id,
  output logic                   busy
);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ptr_q;
  logic [KA_W-1:0]     idle_cnt_q;

  logic [N_CH-1:0]     eligible;
  logic                out_free;
  logic                arb_en;
  logic                do_grant;
  logic                ka_hit;
  logic [N_CH-1:0]     win_vec;
  logic [CH_W-1:0]     win_idx;
  logic                win_valid;
  logic [int_dsize-1:0] sel_ae;
  logic [MAX_EV_W-1:0]  tagged_full;
  logic [int_dsize-1:0] next_ae;

  assign eligible = bus.req_src_rdy & ch_en;
  assign out_free = !bus.tx_src_rdy || bus.tx_dst_rdy;
  // Reset gates the pop strobe so a FIFO never loses an event to a reset cycle.
  assign arb_en   = out_free && (state_q != KA) && !rst;
  assign do_grant = arb_en && win_valid;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (win_vec),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  assign bus.req_dst_rdy = do_grant ? win_vec : '0;

  always_comb begin
    sel_ae      = bus.req_ae[win_idx*int_dsize +: int_dsize];
    tagged_full = MAX_EV_W'(sel_ae);
    if (TAG_EN != 0) tagged_full = tag_event(tagged_full, dsize, CH_W, int'(win_idx));
    next_ae     = tagged_full[int_dsize-1:0];
  end

  assign ka_hit = (state_q == IDLE) && (ka_period != '0) &&
                  (idle_cnt_q == ka_period - KA_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (do_grant)    state_d = SEND;
        else if (ka_hit) state_d = KA;
      end
      SEND: begin
        if (bus.tx_dst_rdy) state_d = do_grant ? SEND : IDLE;
      end
      KA:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q           <= IDLE;
      ptr_q             <= CH_W'(N_CH - 1);
      idle_cnt_q        <= '0;
      bus.tx_src_rdy    <= 1'b0;
      bus.tx_ae         <= '0;
      bus.tx_keep_alive <= 1'b0;
      grant_id          <= '0;
    end else begin
      state_q           <= state_d;
      bus.tx_keep_alive <= (state_d == KA);

      if (do_grant) begin
        bus.tx_ae      <= next_ae;
        bus.tx_src_rdy <= 1'b1;
        grant_id       <= win_idx;
        ptr_q          <= win_idx;
      end else if (bus.tx_src_rdy && bus.tx_dst_rdy) begin
        bus.tx_src_rdy <= 1'b0;
      end

      // Saturation keeps a shortened period from firing until the counter is cleared.
      if (do_grant || state_q == KA || ka_period == '0) begin
        idle_cnt_q <= '0;
      end else if (state_q == IDLE && eligible == '0 && idle_cnt_q != '1) begin
        idle_cnt_q <= idle_cnt_q + KA_W'(1);
      end
    end
  end

  assign busy = bus.tx_src_rdy | bus.tx_keep_alive;

endmodule

// File: tb/tb_hssaer_tx_arbiter.sv
// Self-checking bench for hssaer_tx_arbiter: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_hssaer_tx_arbiter;

  localparam int N_CH      = 4;
  localparam int DSIZE     = 8;
  localparam int INT_DSIZE = 24;
  localparam int TAG_EN    = 1;
  localparam int KA_W      = 16;
  localparam int CH_W      = 2;
  localparam int KA_MAX    = (1 << KA_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] ch_en;
  logic [KA_W-1:0] ka_period;
  logic [CH_W-1:0] grant_id;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  hssaer_tx_arbiter_if #(.N_CH(N_CH), .int_dsize(INT_DSIZE)) bus ();

  hssaer_tx_arbiter #(
    .N_CH(N_CH), .dsize(DSIZE), .int_dsize(INT_DSIZE), .TAG_EN(TAG_EN), .KA_W(KA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .ka_period (ka_period),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INT_DSIZE-1:0] tag_model(input logic [INT_DSIZE-1:0] ae, input int idx);
    logic [INT_DSIZE-1:0] r;
    r = ae;
    if (TAG_EN != 0) r[DSIZE-1 -: CH_W] = CH_W'(idx);
    return r;
  endfunction

  // Behavioural model: what the lane should show this cycle, and what follows.
  logic                 m_ok = 1'b0;
  logic                 m_valid;
  logic [INT_DSIZE-1:0] m_ae;
  int                   m_gid;
  int                   m_ptr;
  logic                 m_ka;
  int                   m_idle;

  logic [N_CH-1:0] e;
  logic            free, found, was_idle, fire;
  int              w, c;
  logic [N_CH-1:0] exp_pop;

  always @(negedge clk) begin
    e     = bus.req_src_rdy & ch_en;
    free  = !m_valid || bus.tx_dst_rdy;
    found = 1'b0;
    w     = 0;
    if (m_ok && free && !m_ka && !rst) begin
      for (int k = 1; k <= N_CH; k++) begin
        c = (m_ptr + k) % N_CH;
        if (!found && e[c]) begin
          found = 1'b1;
          w     = c;
        end
      end
    end
    exp_pop = found ? N_CH'(1 << w) : '0;

    if (m_ok) begin
      check("req_dst_rdy",   bus.req_dst_rdy,   exp_pop);
      check("tx_src_rdy",    bus.tx_src_rdy,    m_valid);
      check("tx_ae",         bus.tx_ae,         m_ae);
      check("grant_id",      grant_id,          m_gid);
      check("tx_keep_alive", bus.tx_keep_alive, m_ka);
      check("busy",          busy,              m_valid | m_ka);
    end

    if (rst) begin
      m_ok = 1'b1; m_valid = 1'b0; m_ae = '0; m_gid = 0;
      m_ptr = N_CH - 1; m_ka = 1'b0; m_idle = 0;
    end else if (m_ok) begin
      was_idle = !m_valid && !m_ka && (e == '0);
      fire     = 1'b0;
      if (m_ka || found || ka_period == '0) begin
        m_idle = 0;
      end else if (was_idle) begin
        fire   = (m_idle + 1 == int'(ka_period));
        m_idle = (m_idle == KA_MAX) ? m_idle : m_idle + 1;
      end
      m_ka = fire;
      if (found) begin
        m_valid = 1'b1;
        m_ae    = tag_model(bus.req_ae[w*INT_DSIZE +: INT_DSIZE], w);
        m_gid   = w;
        m_ptr   = w;
      end else if (m_valid && bus.tx_dst_rdy) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N_CH-1:0] fair_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                    4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N_CH-1:0] mask_exp [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

  initial begin
    int ka_seen;
    logic got;

    rst = 1'b1; ch_en = '1; ka_period = '0;
    bus.req_ae = '0; bus.req_src_rdy = '0; bus.tx_dst_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_tx_src_rdy", bus.tx_src_rdy, 1'b0);
    check("rst_tx_ae",      bus.tx_ae, 24'h0);
    check("rst_grant_id",   grant_id, 2'd0);
    check("rst_busy",       busy, 1'b0);

    // Single requester on ch0.
    step();
    bus.req_ae      = {24'h0C3333, 24'h0B2222, 24'h0A1111, 24'h0000A5};
    bus.req_src_rdy = 4'b0001;
    @(negedge clk);
    check("single_pop", bus.req_dst_rdy, 4'b0001);
    step();
    bus.req_src_rdy = '0;
    @(negedge clk);
    check("single_tx_ae",  bus.tx_ae, 24'h000025);
    check("single_gid",    grant_id, 2'd0);
    check("single_valid",  bus.tx_src_rdy, 1'b1);
    check("single_nopop",  bus.req_dst_rdy, 4'b0000);
    step(); step();

    // Fairness: all valid, one grant per cycle, rotation starts after ch0.
    bus.req_src_rdy = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fair_pop", bus.req_dst_rdy, fair_exp[i]);
      if (i > 0) check("fair_no_bubble", bus.tx_src_rdy, 1'b1);
      step();
    end
    bus.req_src_rdy = '0;
    step(); step();

    // Backpressure with ch2 holding a valid event.
    bus.tx_dst_rdy  = 1'b0;
    bus.req_src_rdy = 4'b0100;
    @(negedge clk);
    check("bp_first_pop", bus.req_dst_rdy, 4'b0100);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_pop", bus.req_dst_rdy, 4'b0000);
      check("bp_hold_ae",  bus.tx_ae, 24'h0B22A2);
      step();
    end
    bus.tx_dst_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_pop", bus.req_dst_rdy, 4'b0100);
    step();
    bus.req_src_rdy = '0;
    step(); step();

    // Channel mask: only 1 and 3 eligible, alternating.
    ch_en = 4'b1010;
    bus.req_src_rdy = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mask_pop", bus.req_dst_rdy, mask_exp[i]);
      step();
    end
    bus.req_src_rdy = '0;
    ch_en = '1;
    step(); step();

    // Disabling a channel does not retract its event already in the output stage.
    bus.tx_dst_rdy  = 1'b0;
    bus.req_src_rdy = 4'b0001;
    step();
    bus.req_src_rdy = '0;
    ch_en = 4'b1110;
    @(negedge clk);
    check("retract_valid", bus.tx_src_rdy, 1'b1);
    check("retract_ae",    bus.tx_ae, 24'h000025);
    step();
    bus.tx_dst_rdy = 1'b1;
    ch_en = '1;
    step(); step();

    // Reset while an event is held under backpressure.
    bus.tx_dst_rdy  = 1'b0;
    bus.req_src_rdy = 4'b0010;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.tx_src_rdy;
    end
    check("wait_tx_valid", got, 1'b1);
    step();
    rst = 1'b1;
    bus.tx_dst_rdy = 1'b1;
    @(negedge clk);
    check("rst_cycle_nopop", bus.req_dst_rdy, 4'b0000);
    step();
    rst = 1'b0;
    bus.req_src_rdy = '0;
    @(negedge clk);
    check("mid_rst_valid", bus.tx_src_rdy, 1'b0);
    check("mid_rst_ae",    bus.tx_ae, 24'h0);
    check("mid_rst_gid",   grant_id, 2'd0);
    check("mid_rst_busy",  busy, 1'b0);
    step();
    bus.req_src_rdy = 4'b1111;
    @(negedge clk);
    check("post_rst_pop", bus.req_dst_rdy, 4'b0001);
    step();
    bus.req_src_rdy = '0;
    step(); step();

    // Keep-alive from a fresh reset: pulses in cycles 4, 9, 14.
    rst = 1'b1;
    ka_period = 16'd4;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("ka_cycle", bus.tx_keep_alive, (k == 4 || k == 9 || k == 14));
    end
    step();
    ka_period = '0;
    ka_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tx_keep_alive) ka_seen++;
    end
    check("ka_disabled_count", ka_seen, 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hssaer_tx_arbiter.md
# hssaer_tx_arbiter

Round-robin scheduler that shares one HSSAER/PAER transmit lane between `N_CH` address-event sources. It owns the lane's `ae`/`src_rdy`/`dst_rdy` handshake and its `keep_alive` input. It sits between the per-source event FIFOs and the TX wrapper, optionally tags each event with its source index, and generates periodic keep-alive requests when the lane is idle.

## Interface
Parameters:
- `N_CH`, 4: number of requesters; power of two, 2..8
- `dsize`, 8: significant event width on the lane
- `int_dsize`, 24: internal event bus width
- `TAG_EN`, 1: if 1, replace `ae[dsize-1 -: CH_W]` with the source index (`CH_W = log2(N_CH)`)
- `KA_W`, 16: keep-alive period counter width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ch_en`  in  N_CH  per-requester enable; disabled channels are never granted
- `ka_period`  in  KA_W  idle cycles before keep-alive; 0 disables keep-alive
- `req_ae`  in  N_CH*int_dsize  requester events; channel i occupies `[i*int_dsize +: int_dsize]`
- `req_src_rdy`  in  N_CH  requester i holds a valid event
- `req_dst_rdy`  out  N_CH  one-hot pop strobe; event i is consumed this cycle
- `tx_ae`  out  int_dsize  event to the TX wrapper (registered)
- `tx_src_rdy`  out  1  `tx_ae` valid (registered)
- `tx_dst_rdy`  in  1  TX wrapper accepts `tx_ae`
- `tx_keep_alive`  out  1  one-cycle keep-alive request to the TX wrapper
- `grant_id`  out  CH_W  source index of the event currently in `tx_ae`
- `busy`  out  1  `tx_src_rdy | tx_keep_alive`

## Operation
- Handshake: a transfer happens on a cycle where valid (`src_rdy`) and ready (`dst_rdy`) are both high. `tx_src_rdy` with `tx_ae` stays stable until accepted.
- Output stage: a 1-entry register. It is "free" when `tx_src_rdy=0`, or when `tx_src_rdy & tx_dst_rdy` in the current cycle.
- Eligible set: `E = req_src_rdy & ch_en`.
- Arbitration runs when the output is free and state ≠ KA:
  - Winner is the first set bit of E, searching from `ptr+1` modulo N_CH.
  - Drive `req_dst_rdy[w]=1` combinationally for that cycle.
  - Load `tx_ae` ← `req_ae[w]`, tagged if `TAG_EN`.
  - Set `tx_src_rdy=1`, `grant_id=w`, `ptr=w`.
- FSM:
  - IDLE → SEND on a grant.
  - SEND → SEND on accept plus a new grant (back-to-back, 1 event/cycle).
  - SEND → IDLE on accept with E=0.
  - IDLE → KA when `ka_period≠0` and `idle_cnt == ka_period-1`.
  - KA → IDLE unconditionally after 1 cycle.
- `idle_cnt` behaviour:
  - Cleared on reset, on any grant, in KA, and whenever `ka_period==0`.
  - Increments in IDLE when E=0, saturating at all-ones.
- KA state: `tx_keep_alive=1` and no grant. A request arriving during KA is granted on the next cycle.
- `req_dst_rdy` is never asserted for a channel with `req_src_rdy=0` or `ch_en=0`. At most one bit is set.
- Clearing `ch_en[i]` while event i sits in the output register does not retract it.
- Reset outputs: `tx_src_rdy=0`, `tx_ae=0`, `tx_keep_alive=0`, `req_dst_rdy=0`, `grant_id=0`, `busy=0`, state IDLE, `ptr=N_CH-1` (channel 0 has first priority), `idle_cnt=0`.
- Reset mid-operation: any held event is discarded and no pop strobe is issued in the reset cycle.

## Timing
- Pop to `tx_src_rdy`: 1 cycle. The event appears on `tx_ae` on the edge after `req_dst_rdy` is high.
- Sustained throughput: 1 event/cycle with `tx_dst_rdy` held high.
- Keep-alive: with E=0 and `tx_src_rdy=0` from cycle 0, `tx_keep_alive` pulses in cycle `ka_period`. The pulse repeats every `ka_period+1` cycles while idle.
- Changing `ka_period` takes effect on the next comparison. If the new period is at or below the current `idle_cnt`, the counter saturates and no keep-alive fires until the next grant or a `ka_period` write to 0.
- `req_dst_rdy` is combinational from `req_src_rdy`, `ch_en`, state, `tx_src_rdy`, `tx_dst_rdy`, `ptr`. All other outputs are registered.

## Structure
- Shared package `hssaer_pkg`:
  - `CH_W` function (clog2)
  - Tag-insertion function
  - State enum (IDLE, SEND, KA)
- Sub-module `rr_arbiter` (N_CH requests, `ptr` in, one-hot grant plus index out; purely combinational), instantiated once.
- FSM, output register and keep-alive counter live in the top module.

## Test plan
- Single requester: ch0 offers 0x0000A5, `tx_dst_rdy=1`.
  - → `req_dst_rdy=0001` for 1 cycle.
  - → Next cycle `tx_ae=0x0000A5` (TAG_EN=0) / `0x000025` (TAG_EN=1, CH_W=2), `grant_id=0`.
- Fairness: all 4 channels always valid, `tx_dst_rdy=1` → grants 0,1,2,3,0,1,… one per cycle, no bubbles.
- Backpressure: `tx_dst_rdy=0` for 5 cycles with ch2 valid.
  - → `tx_ae` stable and no further `req_dst_rdy`.
  - → After release, one accept and the next grant in the same cycle.
- Channel mask: `ch_en=1010`, all valid → only channels 1 and 3 are granted, alternating.
- Keep-alive: `ka_period=4`, no requests → `tx_keep_alive` high in cycles 4, 9, 14. With `ka_period=0` → never high.
- Reset mid-transfer: assert `rst` with `tx_src_rdy=1`, `tx_dst_rdy=0`.
  - → Next cycle all outputs 0.
  - → First post-reset grant goes to ch0.
